// File: rtl/mdc_lane_merger_pkg.sv
// Shared types and default sizes for the MDC FFT lane merger.
package mdc_pkg;

    localparam int MDC_WIDTH = 9;
    localparam int MDC_FRAME = 32;
    localparam int MDC_IDXW  = $clog2(MDC_FRAME);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } merger_state_e;

    typedef struct packed {
        logic signed [MDC_WIDTH-1:0] re;
        logic signed [MDC_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/mdc_lane_merger_if.sv
// Pair-in / sample-out bus of the lane merger; slave is the merger side.
interface mdc_lane_merger_if
    import mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int IDXW  = MDC_IDXW
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_up_re;
    logic signed [WIDTH-1:0] in_up_im;
    logic signed [WIDTH-1:0] in_low_re;
    logic signed [WIDTH-1:0] in_low_im;
    logic                    in_swap;
    logic                    in_sof;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic [IDXW-1:0]         out_index;
    logic                    out_last;
    logic                    frame_err;

    modport slave (
        input  in_valid, in_up_re, in_up_im, in_low_re, in_low_im, in_swap, in_sof, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last, frame_err
    );

    modport master (
        output in_valid, in_up_re, in_up_im, in_low_re, in_low_im, in_swap, in_sof, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last, frame_err
    );
endinterface

// File: rtl/mdc_lane_merger_frame_counter.sv
// Frame index counter: advances per emitted sample, realigns on sof and
// flags sof pulses that arrive off a frame boundary.
module mdc_frame_counter #(
    parameter int FRAME = 32,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_fire,
    input  logic            in_sof,
    input  logic            out_fire,
    input  logic            out_valid,
    output logic [IDXW-1:0] out_index,
    output logic            out_last,
    output logic            frame_err
);
    logic [IDXW-1:0] cnt_q, cnt_d, cnt_adv;
    logic            err_q, err_d;

    // cnt_adv is the index the next loaded head would receive without realign
    always_comb begin
        cnt_adv = out_fire ? cnt_q + 1'b1 : cnt_q;
        cnt_d   = cnt_adv;
        err_d   = err_q;
        if (in_fire && in_sof) begin
            cnt_d = '0;
            if (cnt_adv != '0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign out_index = cnt_q;
    assign out_last  = out_valid && (cnt_q == IDXW'(FRAME - 1));
    assign frame_err = err_q;
endmodule

// File: rtl/mdc_lane_merger.sv
// Merges an upper/lower lane pair into one sample stream, one sample per
// cycle, with a 2-entry head/tail holding register loaded pre-swapped.
module mdc_lane_merger
    import mdc_pkg::*;
#(
    parameter int WIDTH = MDC_WIDTH,
    parameter int FRAME = MDC_FRAME,
    parameter int IDXW  = MDC_IDXW
) (
    input  logic                clk,
    input  logic                rst_n,
    mdc_lane_merger_if.slave    bus
);
    typedef struct packed {
        logic signed [WIDTH-1:0] re;
        logic signed [WIDTH-1:0] im;
    } sample_t;

    merger_state_e state_q, state_d;
    sample_t       head_q, head_d;
    sample_t       tail_q, tail_d;
    sample_t       up_s, low_s;
    logic          in_ready_c;
    logic          out_valid_c;
    logic          in_fire;
    logic          out_fire;

    assign up_s  = '{re: bus.in_up_re,  im: bus.in_up_im};
    assign low_s = '{re: bus.in_low_re, im: bus.in_low_im};

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            EMPTY: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    head_d  = bus.in_swap ? low_s : up_s;
                    tail_d  = bus.in_swap ? up_s  : low_s;
                    state_d = FULL;
                end
            end
            FULL: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            ONE: begin
                out_valid_c = 1'b1;
                // The tail leaving frees both slots, so a new pair may enter on the same edge
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        head_d  = bus.in_swap ? low_s : up_s;
                        tail_d  = bus.in_swap ? up_s  : low_s;
                        state_d = FULL;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign in_fire   = bus.in_valid && in_ready_c;
    assign out_fire  = out_valid_c && bus.out_ready;

    assign bus.in_ready  = in_ready_c && rst_n;
    assign bus.out_valid = out_valid_c;
    assign bus.out_re    = head_q.re;
    assign bus.out_im    = head_q.im;

    mdc_frame_counter #(
        .FRAME (FRAME),
        .IDXW  (IDXW)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_fire   (in_fire),
        .in_sof    (bus.in_sof),
        .out_fire  (out_fire),
        .out_valid (out_valid_c),
        .out_index (bus.out_index),
        .out_last  (bus.out_last),
        .frame_err (bus.frame_err)
    );
endmodule

// File: tb/tb_mdc_lane_merger.sv
// Scoreboard bench for mdc_lane_merger: a pair-level reference model queues
// expected samples; a separate monitor pops them on each output transfer.
module tb_mdc_lane_merger;
    import mdc_pkg::*;

    localparam int W  = 9;
    localparam int FR = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdc_lane_merger_if #(.WIDTH(W), .IDXW(IW)) bus ();

    mdc_lane_merger #(.WIDTH(W), .FRAME(FR), .IDXW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        cplx_t s;
        int    idx;
        bit    last;
        bit    err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   idx_m = 0;
    bit   err_m = 1'b0;
    int   rdy_mode = 0;
    bit   gaps = 1'b0;
    int   cyc = 0;
    int   last_accept = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    // Reference model: indices follow sample order alone, independent of timing
    function automatic void push_sample(input cplx_t s);
        exp_t e;
        e.s    = s;
        e.idx  = idx_m;
        e.last = (idx_m == FR - 1);
        e.err  = err_m;
        sb.push_back(e);
        idx_m = (idx_m + 1) % FR;
    endfunction

    function automatic void model_pair(input cplx_t up, input cplx_t low, input bit sw, input bit sof);
        if (sof) begin
            if (idx_m != 0) err_m = 1'b1;
            idx_m = 0;
        end
        push_sample(sw ? low : up);
        push_sample(sw ? up : low);
    endfunction

    function automatic logic pick_ready();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 1) return ($urandom_range(0, 3) != 0);
        return 1'b0;
    endfunction

    function automatic cplx_t mk(input int re, input int im);
        cplx_t c;
        c.re = W'(re);
        c.im = W'(im);
        return c;
    endfunction

    function automatic cplx_t rnd_c();
        cplx_t c;
        c.re = W'($urandom);
        c.im = W'($urandom);
        return c;
    endfunction

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.in_sof    = 1'b0;
            bus.out_ready = pick_ready();
        end
    endtask

    task automatic drive_pair(input cplx_t up, input cplx_t low, input bit sw, input bit sof, input bit push);
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            bus.in_up_re  = up.re;
            bus.in_up_im  = up.im;
            bus.in_low_re = low.re;
            bus.in_low_im = low.im;
            bus.in_swap   = sw;
            bus.in_sof    = sof;
            bus.in_valid  = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            bus.out_ready = pick_ready();
            #1;
            if (bus.in_valid && bus.in_ready) begin
                done = 1'b1;
                last_accept = cyc;
                if (push) model_pair(up, low, sw, sof);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept_within_100_cycles");
        end
    endtask

    // Monitor: compares each output transfer and checks stability under stall
    initial begin
        exp_t            e;
        bit              hold = 1'b0;
        logic [2*W+IW-1:0] saved = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                checks++;
                if (!bus.out_valid || {bus.out_re, bus.out_im, bus.out_index} !== saved) begin
                    failures++;
                    $display("FAIL stall_stable actual=valid%0b/%h required=valid1/%h",
                             bus.out_valid, {bus.out_re, bus.out_im, bus.out_index}, saved);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sample actual=(%0d,%0d) idx=%0d required=none",
                             bus.out_re, bus.out_im, bus.out_index);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_re !== e.s.re || bus.out_im !== e.s.im || int'(bus.out_index) != e.idx ||
                        bus.out_last !== e.last || bus.frame_err !== e.err) begin
                        failures++;
                        $display("FAIL sample actual=(%0d,%0d) idx=%0d last=%0b err=%0b required=(%0d,%0d) idx=%0d last=%0b err=%0b",
                                 bus.out_re, bus.out_im, bus.out_index, bus.out_last, bus.frame_err,
                                 e.s.re, e.s.im, e.idx, e.last, e.err);
                    end else begin
                        $display("ok   sample (%0d,%0d) idx=%0d last=%0b err=%0b",
                                 e.s.re, e.s.im, e.idx, e.last, e.err);
                    end
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            saved = {bus.out_re, bus.out_im, bus.out_index};
        end
    end

    initial begin
        int first_acc;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_swap = 1'b0; bus.out_ready = 1'b0;
        bus.in_up_re = '0; bus.in_up_im = '0; bus.in_low_re = '0; bus.in_low_im = '0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_index", int'(bus.out_index), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(bus.in_ready), 1);

        // Reset asserted while FULL and stalled: the pair must vanish
        rdy_mode = 2;
        drive_pair(mk(11, 12), mk(13, 14), 1'b0, 1'b0, 1'b0);
        drive_idle(1);
        #1;
        chk("full_before_reset", int'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_out_re", int'(bus.out_re), 0);
        chk("midrst_out_im", int'(bus.out_im), 0);
        chk("midrst_out_index", int'(bus.out_index), 0);
        chk("midrst_out_last", int'(bus.out_last), 0);
        chk("midrst_frame_err", int'(bus.frame_err), 0);
        rdy_mode = 0;
        drive_idle(1);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", int'(bus.in_ready), 1);
        chk("release_out_valid", int'(bus.out_valid), 0);

        // Ordering and latency, swap off then on
        for (int sw = 0; sw < 2; sw++) begin
            drive_pair(mk(3, -4), mk(-256, 255), sw[0], 1'b0, 1'b1);
            drive_idle(1);
            #1;
            chk("order_first_valid", int'(bus.out_valid), 1);
            chk("order_first_re", int'(bus.out_re), sw ? -256 : 3);
            drive_idle(1);
            #1;
            chk("order_second_re", int'(bus.out_re), sw ? 3 : -256);
            drive_idle(1);
        end

        // Backpressure while FULL
        rdy_mode = 2;
        drive_pair(mk(-256, -256), mk(255, 1), 1'b0, 1'b0, 1'b1);
        repeat (5) begin
            drive_idle(1);
            #1;
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
        end
        rdy_mode = 0;
        drive_idle(4);

        // Pad to a frame boundary, then one aligned back-to-back frame
        while (idx_m != 0) drive_pair(rnd_c(), rnd_c(), 1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 16; p++) begin
            drive_pair(rnd_c(), rnd_c(), $urandom_range(0, 1), (p == 0), 1'b1);
            if (p == 0) first_acc = last_accept;
        end
        chk("stream_pair_rate", last_accept - first_acc, 30);
        drive_idle(3);
        chk("aligned_no_err", int'(bus.frame_err), 0);

        // Misaligned sof on pair 3, then a correct frame
        for (int p = 0; p < 19; p++)
            drive_pair(rnd_c(), rnd_c(), 1'b0, (p == 3), 1'b1);
        for (int p = 0; p < 16; p++)
            drive_pair(rnd_c(), rnd_c(), 1'b0, (p == 0), 1'b1);
        drive_idle(3);
        chk("err_sticky", int'(bus.frame_err), 1);

        // Randomized traffic with gaps and random backpressure
        gaps = 1'b1;
        rdy_mode = 1;
        for (int p = 0; p < 300; p++)
            drive_pair(rnd_c(), rnd_c(), $urandom_range(0, 1), ($urandom_range(0, 7) == 0), 1'b1);

        gaps = 1'b0;
        rdy_mode = 0;
        for (int t = 0; t < 200 && sb.size() != 0; t++) drive_idle(1);
        drive_idle(2);
        chk("drain_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdc_lane_merger.md
Name: mdc_lane_merger

Overview:
- Output-side counterpart of the input commutator in the 32-point MDC FFT. The input commutator splits one stream onto upper/lower lanes; this block merges the two lanes back into one sample stream.
- Accepts one upper+lower complex pair per handshake and emits the two samples one per cycle, in programmable order.
- Tags each output sample with its frame index and a last flag. Sits between the final butterfly stage and the bit-reversal/output buffer.

Parameters:
- WIDTH, 9, bit width of each signed real/imag component.
- FRAME, 32, output samples per frame; must be a power of two, at least 2.
- IDXW, 5, width of out_index; must equal log2(FRAME).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_up_re  in  WIDTH  signed upper-lane real.
- in_up_im  in  WIDTH  signed upper-lane imag.
- in_low_re  in  WIDTH  signed lower-lane real.
- in_low_im  in  WIDTH  signed lower-lane imag.
- in_swap  in  1  0: emit upper then lower; 1: emit lower then upper (sampled with pair).
- in_sof  in  1  pair starts a new frame (sampled with pair).
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_re  out  WIDTH  signed output real.
- out_im  out  WIDTH  signed output imag.
- out_index  out  IDXW  index of the current sample within the frame.
- out_last  out  1  high when out_index == FRAME-1 and out_valid.
- frame_err  out  1  sticky: in_sof arrived off a frame boundary.

Behaviour:
- Reset (async, rst_n low), effective immediately regardless of state:
  - state=EMPTY; out_valid=0, out_re=0, out_im=0, out_index=0, out_last=0, frame_err=0; in_ready=1 once rst_n is released.
  - A transfer pending when reset asserts is discarded; no partial sample is emitted after release.
- Storage is a 2-entry holding register: head (first sample) and tail (second sample), loaded with swap already applied.
  - Swap applies to this pair only; no re-ordering across pairs. out_re/out_im always show head.
- Handshakes:
  - Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
  - Inputs are ignored when in_ready=0. out_re/im/index must stay stable while out_valid=1 and out_ready=0.
- FSM:
  - EMPTY: in_ready=1, out_valid=0. On input transfer, load head/tail and go to FULL.
  - FULL: in_ready=0, out_valid=1. On output transfer, head<=tail and go to ONE.
  - ONE: out_valid=1; in_ready=out_ready, which is the only combinational input-to-output path.
    - Output transfer with no input transfer: go to EMPTY.
    - Output transfer and input transfer together: load the new pair and go to FULL. This gives back-to-back throughput of 1 sample per cycle and 1 pair per 2 cycles.
- Latency: pair accepted at edge N; first sample valid in cycle N+1, second in cycle N+2 if out_ready is held high.
- Index counter:
  - Increments on each output transfer and wraps FRAME-1 -> 0 (natural IDXW-bit wrap).
  - On input transfer with in_sof=1, the counter is forced to 0 for that pair's first sample.
  - If in_sof=1 and the counter is not already 0 at the moment the pair's first sample is emitted, set frame_err. frame_err clears only on reset.
  - in_sof=1 on the very first pair after reset does not set frame_err.
  - out_last is combinational from out_index and out_valid.
- No arithmetic or width change: samples pass bit-exact, including most-negative values.

Decomposition:
- Shared package mdc_pkg: state enum (EMPTY, ONE, FULL), FRAME/IDXW constants, and a complex-sample struct of re/im at WIDTH.
- Natural sub-module: mdc_frame_counter, containing the IDXW counter, sof realign, frame_err and out_last. The FSM plus holding registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 mid-FULL with out_ready=0 -> all outputs 0, frame_err=0. After release, in_ready=1 and the old pair is never emitted.
- Order: pair up=(3,-4), low=(-256,255), swap=0, out_ready=1 -> out (3,-4) at N+1, (-256,255) at N+2. Same pair with swap=1 -> reversed order.
- Streaming: 16 back-to-back pairs, sof on pair 0, out_ready=1 -> 32 consecutive valid samples, index 0..31, out_last only at index 31, in_ready pattern 1,0,1,0...
- Backpressure: out_ready=0 for 5 cycles while FULL -> out_valid held, data/index stable, in_ready=0. Then out_ready=1 -> both samples drain with no loss or duplication.
- Misaligned sof: in_sof on pair 3 (first sample would be index 6) -> that sample shows index 0, frame_err rises and stays 1 through the next correct frame.
- Simultaneous event: in ONE with in_valid=1 and out_ready=1 in the same cycle -> tail emitted and new pair loaded in one edge, no bubble on out_valid.
